// File: rtl/clk_div_prog.sv
// Programmable integer divider: clk_out/tick/ratio_ack are registered next-state decodes, 1 cycle after enable.
// No backpressure; ratio changes and stops take effect only at period boundaries.
module clk_div_prog #(
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [CNT_W-1:0] div_ratio,
  input  logic             load,
  output logic             clk_out,
  output logic             tick,
  output logic             ratio_ack,
  output logic             running
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [CNT_W-1:0] DEF_RATIO = CNT_W'(DEFAULT_DIV);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] active, active_nxt;
  logic [CNT_W-1:0] shadow, shadow_nxt;
  logic             pending, pending_nxt;
  logic [CNT_W-1:0] ratio_clamped, ratio_eff, half_nxt;
  logic             apply, terminal;
  logic             clk_out_nxt, tick_nxt, ack_nxt;

  assign ratio_clamped = (div_ratio < CNT_W'(2)) ? CNT_W'(2) : div_ratio;
  // A load in the same cycle as a boundary is used directly, not via the shadow.
  assign ratio_eff     = load ? ratio_clamped : shadow;
  assign terminal      = (cnt == active - CNT_W'(1));
  assign running       = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      active    <= DEF_RATIO;
      shadow    <= DEF_RATIO;
      pending   <= 1'b0;
      clk_out   <= 1'b0;
      tick      <= 1'b0;
      ratio_ack <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      active    <= active_nxt;
      shadow    <= shadow_nxt;
      pending   <= pending_nxt;
      clk_out   <= clk_out_nxt;
      tick      <= tick_nxt;
      ratio_ack <= ack_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    apply     = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
          apply     = 1'b1;
        end
      end
      RUN, DRAIN: begin
        if (terminal) begin
          cnt_nxt = '0;
          if (enable) begin
            state_nxt = RUN;
            apply     = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt   = cnt + CNT_W'(1);
          state_nxt = enable ? RUN : DRAIN;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
    active_nxt  = apply ? ratio_eff : active;
    shadow_nxt  = load ? ratio_clamped : shadow;
    pending_nxt = apply ? 1'b0 : (load | pending);
  end

  // ceil(active/2) without needing an extra bit for active+1.
  always_comb begin
    half_nxt    = (active_nxt >> 1) + CNT_W'(active_nxt[0]);
    clk_out_nxt = (state_nxt != IDLE) && (cnt_nxt < half_nxt);
    tick_nxt    = (state_nxt != IDLE) && (cnt_nxt == active_nxt - CNT_W'(1));
    ack_nxt     = apply && (pending || load);
  end

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog; expected vectors are {clk_out, tick, ratio_ack, running}.
module tb_clk_div_prog;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic       load;
  logic [7:0] div_ratio;
  logic       clk_out, tick, ratio_ack, running;
  logic [3:0] got;

  int n_vec = 0;
  int n_err = 0;
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  clk_div_prog #(.CNT_W(8), .DEFAULT_DIV(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .enable    (enable),
    .div_ratio (div_ratio),
    .load      (load),
    .clk_out   (clk_out),
    .tick      (tick),
    .ratio_ack (ratio_ack),
    .running   (running)
  );

  assign got = {clk_out, tick, ratio_ack, running};

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic void push_period(int n, bit ack);
    for (int c = 0; c < n; c++)
      exp_q.push_back({(c < (n + 1) / 2), (c == n - 1), (ack && c == 0), 1'b1});
  endfunction

  function automatic void push_idle(int k);
    for (int c = 0; c < k; c++) exp_q.push_back(4'b0000);
  endfunction

  task automatic test_reset();
    reset_n = 1'b1; enable = 1'b0; load = 1'b0; div_ratio = 8'd0;
    #2 reset_n = 1'b0;
    #1;
    n_vec++;
    if (got !== 4'b0000) begin
      n_err++; $display("FAIL reset_async: got %b expected 0000", got);
    end
    cyc(); cyc();
    n_vec++;
    if (got !== 4'b0000) begin
      n_err++; $display("FAIL reset_held: got %b expected 0000", got);
    end
    @(negedge clk) reset_n = 1'b1;
  endtask

  task automatic test_default();
    push_idle(1);
    push_period(4, 0); push_period(4, 0); push_period(4, 0);
    for (int i = 0; i < exp_q.size(); i++) begin
      cyc();
      n_vec++;
      if (got !== exp_q[i]) begin
        n_err++; $display("FAIL default_n4 idx %0d: got %b expected %b", i, got, exp_q[i]);
      end
      if (i == 0) enable = 1'b1;
    end
    exp_q.delete();
  endtask

  task automatic test_load_mid();
    push_period(4, 0); push_period(7, 1); push_period(7, 0);
    for (int i = 0; i < exp_q.size(); i++) begin
      cyc();
      n_vec++;
      if (got !== exp_q[i]) begin
        n_err++; $display("FAIL load_mid_n7 idx %0d: got %b expected %b", i, got, exp_q[i]);
      end
      case (i)
        0: begin load = 1'b1; div_ratio = 8'd7; end
        1: load = 1'b0;
        default: ;
      endcase
    end
    exp_q.delete();
  endtask

  task automatic test_double_load();
    push_period(7, 0); push_period(6, 1); push_period(6, 0);
    for (int i = 0; i < exp_q.size(); i++) begin
      cyc();
      n_vec++;
      if (got !== exp_q[i]) begin
        n_err++; $display("FAIL double_load idx %0d: got %b expected %b", i, got, exp_q[i]);
      end
      case (i)
        0: begin load = 1'b1; div_ratio = 8'd5; end
        1: load = 1'b0;
        3: begin load = 1'b1; div_ratio = 8'd6; end
        4: load = 1'b0;
        default: ;
      endcase
    end
    exp_q.delete();
  endtask

  task automatic test_clamp();
    push_period(6, 0); push_period(2, 1); push_period(2, 0);
    push_period(2, 1); push_period(2, 0);
    for (int i = 0; i < exp_q.size(); i++) begin
      cyc();
      n_vec++;
      if (got !== exp_q[i]) begin
        n_err++; $display("FAIL clamp_n2 idx %0d: got %b expected %b", i, got, exp_q[i]);
      end
      case (i)
        0: begin load = 1'b1; div_ratio = 8'd0; end
        1: load = 1'b0;
        8: begin load = 1'b1; div_ratio = 8'd1; end
        9: load = 1'b0;
        default: ;
      endcase
    end
    exp_q.delete();
  endtask

  task automatic test_drain();
    load = 1'b1; div_ratio = 8'd6;
    push_period(6, 1); push_idle(2); push_period(6, 0); push_period(6, 0);
    for (int i = 0; i < exp_q.size(); i++) begin
      cyc();
      n_vec++;
      if (got !== exp_q[i]) begin
        n_err++; $display("FAIL drain_n6 idx %0d: got %b expected %b", i, got, exp_q[i]);
      end
      case (i)
        0:  load = 1'b0;
        1:  enable = 1'b0;
        7:  enable = 1'b1;
        9:  enable = 1'b0;
        11: enable = 1'b1;
        default: ;
      endcase
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    load = 1'b1; div_ratio = 8'd8;
    push_period(8, 1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_vec++;
      if (got !== exp_q[i]) begin
        n_err++; $display("FAIL reset_mid_n8 idx %0d: got %b expected %b", i, got, exp_q[i]);
      end
      if (i == 0) load = 1'b0;
    end
    exp_q.delete();
    #2 reset_n = 1'b0;
    #1;
    n_vec++;
    if (got !== 4'b0000) begin
      n_err++; $display("FAIL reset_mid_async: got %b expected 0000", got);
    end
    enable = 1'b0;
    cyc(); cyc();
    n_vec++;
    if (got !== 4'b0000) begin
      n_err++; $display("FAIL reset_mid_held: got %b expected 0000", got);
    end
    @(negedge clk) begin reset_n = 1'b1; enable = 1'b1; end
    push_period(4, 0); push_period(8, 1);
    for (int i = 0; i < exp_q.size(); i++) begin
      cyc();
      n_vec++;
      if (got !== exp_q[i]) begin
        n_err++; $display("FAIL post_reset idx %0d: got %b expected %b", i, got, exp_q[i]);
      end
      case (i)
        3: begin load = 1'b1; div_ratio = 8'd8; end
        4: load = 1'b0;
        default: ;
      endcase
    end
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_default();
    test_load_mid();
    test_double_load();
    test_clamp();
    test_drain();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/clk_div_prog.md
Name: clk_div_prog

Overview:
- Programmable integer clock divider that sits directly downstream of the toggle flip-flop stage.
- In the system its clk input is the divide-by-2 clock produced by that stage.
- It produces the slower timing clocks (clk_out) and period strobes (tick) used by the readout and ADC sequencing logic.
- Ratio changes are glitch-free because new ratios are applied only at period boundaries. Start and stop are clean: only whole periods are emitted.

Parameters:
CNT_W, 8, width of divide ratio and internal period counter
DEFAULT_DIV, 4, ratio loaded into the shadow register at reset (must be >= 2 and < 2**CNT_W)

Ports:
clk  input  1  divider input clock
reset_n  input  1  asynchronous, active-low reset
enable  input  1  run request; level-sensitive
div_ratio  input  CNT_W  requested divide ratio N; captured only when load=1
load  input  1  single-cycle request to capture div_ratio into the shadow register
clk_out  output  1  divided clock, registered
tick  output  1  registered strobe, high for the last clk cycle of every output period
ratio_ack  output  1  registered one-cycle pulse in the first cycle of a period that uses a newly applied ratio
running  output  1  high whenever state != IDLE

Behaviour:
- Reset (async assert, sync-to-clk release by the system):
  - state=IDLE, cnt=0, clk_out=0, tick=0, ratio_ack=0, running=0.
  - shadow=DEFAULT_DIV, active=DEFAULT_DIV, pending=0.
- Ratio clamp: any captured value < 2 is stored as 2. N=0/1 is never used.
- Shadow register:
  - load=1 writes clamp(div_ratio) to shadow and sets pending=1.
  - A second load before application overwrites shadow; only one ratio_ack is produced.
- Effective next ratio: if load=1 in the same cycle, use clamp(div_ratio) (bypass); otherwise use shadow.
- H = ceil(active/2).
- Output decode: clk_out and tick are flops updated from next-state values, so in any cycle:
  - clk_out = (state!=IDLE) && (cnt < H)
  - tick = (state!=IDLE) && (cnt == active-1)
  - Even N gives 50% duty. Odd N gives high for (N+1)/2 cycles and low for (N-1)/2 cycles.
- FSM states: IDLE, RUN, DRAIN.
- IDLE:
  - outputs low.
  - enable=1 at an edge -> RUN, cnt=0, active=effective ratio, pending cleared.
  - ratio_ack=1 in that first cycle if pending (or load) applied.
  - clk_out rises 1 cycle after enable is sampled.
- RUN, non-terminal cycle: cnt++.
  - enable=0 -> DRAIN; cnt keeps counting.
- RUN, terminal cycle (cnt==active-1):
  - enable=1 -> cnt=0, active=effective ratio, ratio_ack=1 next cycle if a new ratio was applied.
  - enable=0 -> IDLE.
- DRAIN: finishes the current period exactly as RUN would.
  - enable=1 again before terminal -> back to RUN, no disturbance to cnt or outputs.
  - At terminal with enable=0 -> IDLE; clk_out is low from the following cycle.
- Guarantees:
  - No period is ever truncated or extended by load or enable.
  - clk_out never has a high or low phase shorter than floor(active/2) cycles.
- Reset mid-period: outputs drop to 0 asynchronously. The next enable starts with DEFAULT_DIV.
- cnt width is CNT_W. Maximum ratio is 2**CNT_W-1, so cnt never wraps past active-1.

Test Plan:
- Reset, enable=1, default N=4 -> clk_out 1,1,0,0 repeating from 1 cycle after enable; tick high on every 4th cycle; ratio_ack stays 0.
- Running at N=4, load=1 with div_ratio=7 mid-period -> current period completes as 4 cycles; next period is 7 cycles with 4 high and 3 low; ratio_ack pulses once in the first cycle of the 7-cycle period.
- load div_ratio=5 then div_ratio=6 before the boundary -> only 6 is applied; exactly one ratio_ack.
- load div_ratio=0 and div_ratio=1 -> both behave as N=2: clk_out toggles each cycle and tick is high every 2nd cycle.
- N=6, enable dropped at cnt=1 -> 4 more cycles complete the period, then IDLE with clk_out=0 and running=0. A re-enable at cnt=3 in DRAIN gives a seamless continuation.
- Assert reset_n=0 at cnt=2 of an N=8 period -> all outputs 0 immediately. After release, enable yields N=8 only if reloaded, otherwise DEFAULT_DIV=4.
